// File: rtl/rv32i_single_cycle_core.sv
// Single-cycle RV32I core: instruction ROM, register file and data RAM are all internal.
// Optional macro ECALL_HALT_EN: ECALL/EBREAK latch a sticky halt that freezes PC and all writes until rst.
module rv32i_single_cycle_core #(
  parameter int    IMEM_WORDS = 64,
  parameter int    DMEM_BYTES = 256,
  parameter string IMEM_INIT  = "program.hex"
) (
  input logic clk,
  input logic rst
);
  localparam int IAW = (IMEM_WORDS > 1) ? $clog2(IMEM_WORDS) : 1;
  localparam int DAW = (DMEM_BYTES > 1) ? $clog2(DMEM_BYTES) : 1;

  typedef enum logic [6:0] {
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111,
    OPC_JAL    = 7'b1101111,
    OPC_JALR   = 7'b1100111,
    OPC_BRANCH = 7'b1100011,
    OPC_LOAD   = 7'b0000011,
    OPC_STORE  = 7'b0100011,
    OPC_OPIMM  = 7'b0010011,
    OPC_OP     = 7'b0110011
  } opcode_t;

  logic [31:0] imem [IMEM_WORDS];
  logic [7:0]  dmem [DMEM_BYTES];
  logic [31:0] regs [32];
  logic [31:0] pc;

  logic [IAW-1:0] imem_idx;
  logic [31:0]    inst, imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [6:0]     opcode;
  logic [4:0]     rd, rs1, rs2;
  logic [2:0]     funct3;
  logic [31:0]    rs1_val, rs2_val, alu_b, alu_out, mem_addr, load_val;
  logic [31:0]    wb_val, next_pc, pc_plus4;
  logic [DAW-1:0] byte_idx [4];
  logic [7:0]     ld_byte [4];
  logic [3:0]     byte_en;
  logic           reg_we, is_sub, taken, stall;

  assign imem_idx = IAW'({2'b00, pc[31:2]} % 32'(IMEM_WORDS));
  assign inst     = imem[imem_idx];
  assign opcode   = inst[6:0];
  assign rd       = inst[11:7];
  assign funct3   = inst[14:12];
  assign rs1      = inst[19:15];
  assign rs2      = inst[24:20];
  assign imm_i    = {{20{inst[31]}}, inst[31:20]};
  assign imm_s    = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b    = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u    = {inst[31:12], 12'b0};
  assign imm_j    = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  assign rs1_val  = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
  assign rs2_val  = (rs2 == 5'd0) ? 32'd0 : regs[rs2];
  assign pc_plus4 = pc + 32'd4;

  always_comb begin
    alu_b   = (opcode == OPC_OP) ? rs2_val : imm_i;
    is_sub  = (opcode == OPC_OP) && inst[30];
    alu_out = '0;
    case (funct3)
      3'b000:  alu_out = is_sub ? rs1_val - alu_b : rs1_val + alu_b;
      3'b001:  alu_out = rs1_val << alu_b[4:0];
      3'b010:  alu_out = {31'b0, $signed(rs1_val) < $signed(alu_b)};
      3'b011:  alu_out = {31'b0, rs1_val < alu_b};
      3'b100:  alu_out = rs1_val ^ alu_b;
      3'b101:  alu_out = inst[30] ? 32'($signed(rs1_val) >>> alu_b[4:0]) : rs1_val >> alu_b[4:0];
      3'b110:  alu_out = rs1_val | alu_b;
      default: alu_out = rs1_val & alu_b;
    endcase
  end

  // Every access is handled as four independent byte lanes so misaligned addresses wrap naturally.
  always_comb begin
    mem_addr = rs1_val + ((opcode == OPC_STORE) ? imm_s : imm_i);
    for (int k = 0; k < 4; k++) begin
      byte_idx[k] = DAW'((mem_addr + 32'(k)) % 32'(DMEM_BYTES));
      ld_byte[k]  = dmem[byte_idx[k]];
    end
    case (funct3)
      3'b000:  load_val = {{24{ld_byte[0][7]}}, ld_byte[0]};
      3'b001:  load_val = {{16{ld_byte[1][7]}}, ld_byte[1], ld_byte[0]};
      3'b100:  load_val = {24'b0, ld_byte[0]};
      3'b101:  load_val = {16'b0, ld_byte[1], ld_byte[0]};
      default: load_val = {ld_byte[3], ld_byte[2], ld_byte[1], ld_byte[0]};
    endcase
  end

  always_comb begin
    taken = 1'b0;
    case (funct3)
      3'b000:  taken = (rs1_val == rs2_val);
      3'b001:  taken = (rs1_val != rs2_val);
      3'b100:  taken = ($signed(rs1_val) < $signed(rs2_val));
      3'b101:  taken = ($signed(rs1_val) >= $signed(rs2_val));
      3'b110:  taken = (rs1_val < rs2_val);
      3'b111:  taken = (rs1_val >= rs2_val);
      default: taken = 1'b0;
    endcase
  end

`ifdef ECALL_HALT_EN
  logic halted, is_halt_inst;
  assign is_halt_inst = (inst == 32'h0000_0073) || (inst == 32'h0010_0073);
  assign stall        = halted || is_halt_inst;

  always_ff @(posedge clk) begin
    if (rst)               halted <= 1'b0;
    else if (is_halt_inst) halted <= 1'b1;
  end
`else
  assign stall = 1'b0;
`endif

  always_comb begin
    next_pc = pc_plus4;
    wb_val  = alu_out;
    reg_we  = 1'b0;
    byte_en = 4'b0000;
    case (opcode)
      OPC_LUI:    begin reg_we = 1'b1; wb_val = imm_u; end
      OPC_AUIPC:  begin reg_we = 1'b1; wb_val = pc + imm_u; end
      OPC_JAL:    begin reg_we = 1'b1; wb_val = pc_plus4; next_pc = pc + imm_j; end
      OPC_JALR:   begin reg_we = 1'b1; wb_val = pc_plus4; next_pc = (rs1_val + imm_i) & ~32'd1; end
      OPC_BRANCH: if (taken) next_pc = pc + imm_b;
      OPC_LOAD:   begin
        wb_val = load_val;
        reg_we = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      end
      OPC_STORE:  begin
        case (funct3)
          3'b000:  byte_en = 4'b0001;
          3'b001:  byte_en = 4'b0011;
          3'b010:  byte_en = 4'b1111;
          default: byte_en = 4'b0000;
        endcase
      end
      OPC_OPIMM, OPC_OP: reg_we = 1'b1;
      default: ;
    endcase
    if (stall) begin
      next_pc = pc;
      reg_we  = 1'b0;
      byte_en = 4'b0000;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= '0;
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else begin
      pc <= next_pc;
      if (reg_we && rd != 5'd0) regs[rd] <= wb_val;
    end
  end

  // Data memory is deliberately left out of reset so stores survive a restart.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 4; k++)
        if (byte_en[k]) dmem[byte_idx[k]] <= rs2_val[8*k +: 8];
    end
  end

endmodule

// File: tb/tb_rv32i_single_cycle_core.sv
// Directed programs written straight into the core's instruction ROM; architectural state
// is read hierarchically at the falling edge after each retiring rising edge.
module tb_rv32i_single_cycle_core;
  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  localparam logic [31:0] NOP       = 32'h0000_0013;
  localparam logic [6:0]  OP_IMM    = 7'b0010011;
  localparam logic [6:0]  OP_LOAD   = 7'b0000011;
  localparam logic [6:0]  OP_JALR   = 7'b1100111;
  localparam logic [6:0]  OP_LUI    = 7'b0110111;
  localparam logic [6:0]  OP_AUIPC  = 7'b0010111;

  rv32i_single_cycle_core #(
    .IMEM_WORDS(64),
    .DMEM_BYTES(256),
    .IMEM_INIT ("")
  ) dut (
    .clk(clk),
    .rst(rst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] encI(input int imm, input int rs1, input int f3, input int rd, input logic [6:0] op);
    return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op};
  endfunction

  function automatic logic [31:0] encR(input int f7, input int rs2, input int rs1, input int f3, input int rd);
    return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'b0110011};
  endfunction

  function automatic logic [31:0] encS(input int imm, input int rs2, input int rs1, input int f3);
    return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] encB(input int imm, input int rs2, input int rs1, input int f3);
    return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] encJ(input int imm, input int rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'b1101111};
  endfunction

  function automatic logic [31:0] encU(input int imm20, input int rd, input logic [6:0] op);
    return {imm20[19:0], rd[4:0], op};
  endfunction

  function automatic logic [31:0] addi(input int rd, input int rs1, input int imm);
    return encI(imm, rs1, 0, rd, OP_IMM);
  endfunction

  task automatic clearProgram();
    for (int i = 0; i < 64; i++) dut.imem[i] = NOP;
  endtask

  task automatic setInst(input int byte_addr, input logic [31:0] word);
    dut.imem[byte_addr / 4] = word;
  endtask

  // Called at a falling edge; rst is held across exactly one rising edge.
  task automatic beginReset();
    rst = 1'b1;
  endtask

  task automatic endReset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic applyStimulus(input int cycles);
    repeat (cycles) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    @(negedge clk);

    // Reset state
    beginReset();
    clearProgram();
    endReset();
    checkOutput("reset_pc", dut.pc, 32'h0);
    for (int i = 1; i < 32; i++) checkOutput($sformatf("reset_x%0d", i), dut.regs[i], 32'h0);
    applyStimulus(1);
    checkOutput("pc_after_first_edge", dut.pc, 32'h4);

    // Arithmetic
    beginReset();
    clearProgram();
    setInst(0,  addi(1, 0, 5));
    setInst(4,  addi(2, 0, -3));
    setInst(8,  encR(0, 2, 1, 0, 3));
    setInst(12, encR(32, 1, 2, 0, 4));
    setInst(16, encI(32'h401, 2, 5, 5, OP_IMM));
    setInst(20, encR(0, 2, 1, 3, 6));
    setInst(24, encR(0, 1, 2, 2, 7));
    setInst(28, encI(15, 2, 4, 8, OP_IMM));
    setInst(32, encI(28, 2, 5, 9, OP_IMM));
    setInst(36, encR(0, 1, 1, 1, 10));
    setInst(40, encU(32'h12345, 11, OP_LUI));
    setInst(44, encU(1, 12, OP_AUIPC));
    endReset();
    applyStimulus(12);
    checkOutput("add_x3",   dut.regs[3],  32'h0000_0002);
    checkOutput("sub_x4",   dut.regs[4],  32'hFFFF_FFF8);
    checkOutput("srai_x5",  dut.regs[5],  32'hFFFF_FFFE);
    checkOutput("sltu_x6",  dut.regs[6],  32'h0000_0001);
    checkOutput("slt_x7",   dut.regs[7],  32'h0000_0001);
    checkOutput("xori_x8",  dut.regs[8],  32'hFFFF_FFF2);
    checkOutput("srli_x9",  dut.regs[9],  32'h0000_000F);
    checkOutput("sll_x10",  dut.regs[10], 32'h0000_00A0);
    checkOutput("lui_x11",  dut.regs[11], 32'h1234_5000);
    checkOutput("auipc_x12", dut.regs[12], 32'h0000_102C);
    checkOutput("arith_pc", dut.pc, 32'd48);

    // Loads and stores, including a word store that wraps past the top of memory
    beginReset();
    clearProgram();
    setInst(0,  addi(1, 0, 32'h80));
    setInst(4,  encS(0, 1, 0, 2));
    setInst(8,  encI(0, 0, 0, 2, OP_LOAD));
    setInst(12, encI(0, 0, 4, 3, OP_LOAD));
    setInst(16, encS(6, 1, 0, 1));
    setInst(20, encI(6, 0, 1, 4, OP_LOAD));
    setInst(24, addi(6, 0, -1));
    setInst(28, encS(254, 6, 0, 2));
    setInst(32, encI(0, 0, 2, 7, OP_LOAD));
    setInst(36, encI(255, 0, 5, 8, OP_LOAD));
    setInst(40, encI(1, 0, 0, 9, OP_LOAD));
    setInst(44, encS(3, 6, 0, 0));
    setInst(48, encI(0, 0, 2, 10, OP_LOAD));
    endReset();
    applyStimulus(13);
    checkOutput("lb_x2",        dut.regs[2],  32'hFFFF_FF80);
    checkOutput("lbu_x3",       dut.regs[3],  32'h0000_0080);
    checkOutput("lh_x4",        dut.regs[4],  32'h0000_0080);
    checkOutput("lw_wrap_x7",   dut.regs[7],  32'h0000_FFFF);
    checkOutput("lhu_wrap_x8",  dut.regs[8],  32'h0000_FFFF);
    checkOutput("lb_neg_x9",    dut.regs[9],  32'hFFFF_FFFF);
    checkOutput("sb_lw_x10",    dut.regs[10], 32'hFF00_FFFF);
    checkOutput("dmem_255",     {24'b0, dut.dmem[255]}, 32'h0000_00FF);

    // Branches and JAL
    beginReset();
    clearProgram();
    setInst(32'h00, addi(2, 0, -1));
    setInst(32'h04, addi(1, 0, 1));
    setInst(32'h08, encB(8, 0, 0, 0));
    setInst(32'h0C, addi(3, 0, 9));
    setInst(32'h10, encJ(12, 1));
    setInst(32'h14, addi(3, 0, 7));
    setInst(32'h1C, encB(8, 1, 2, 6));
    setInst(32'h20, encB(8, 1, 2, 4));
    setInst(32'h24, addi(3, 0, 5));
    setInst(32'h28, encB(8, 1, 1, 1));
    setInst(32'h2C, addi(3, 0, 1));
    endReset();
    applyStimulus(3);
    checkOutput("beq_taken_pc", dut.pc, 32'h10);
    applyStimulus(1);
    checkOutput("jal_link_x1", dut.regs[1], 32'h14);
    checkOutput("jal_pc", dut.pc, 32'h1C);
    applyStimulus(1);
    checkOutput("bltu_not_taken_pc", dut.pc, 32'h20);
    applyStimulus(1);
    checkOutput("blt_taken_pc", dut.pc, 32'h28);
    applyStimulus(1);
    checkOutput("bne_not_taken_pc", dut.pc, 32'h2C);
    applyStimulus(1);
    checkOutput("skipped_and_final_x3", dut.regs[3], 32'h1);

    // x0 stays zero; JALR clears bit 0 and links from the old rs1 when rd==rs1
    beginReset();
    clearProgram();
    setInst(32'h00, addi(0, 0, 7));
    setInst(32'h04, addi(6, 0, 32'h20));
    setInst(32'h08, encI(3, 6, 0, 5, OP_JALR));
    setInst(32'h10, encR(0, 6, 0, 0, 8));
    setInst(32'h20, addi(7, 0, 1));
    setInst(32'h24, encI(16, 7, 0, 7, OP_JALR));
    endReset();
    applyStimulus(1);
    checkOutput("x0_discard", dut.regs[0], 32'h0);
    applyStimulus(2);
    checkOutput("jalr_pc", dut.pc, 32'h22);
    checkOutput("jalr_link_x5", dut.regs[5], 32'h0C);
    applyStimulus(1);
    checkOutput("misaligned_fetch_x7", dut.regs[7], 32'h1);
    applyStimulus(1);
    checkOutput("jalr_same_reg_pc", dut.pc, 32'h10);
    checkOutput("jalr_same_reg_x7", dut.regs[7], 32'h2A);
    applyStimulus(1);
    checkOutput("x0_read_x8", dut.regs[8], 32'h20);

    // Mid-run reset: the store sitting at PC during the reset edge must not land
    beginReset();
    clearProgram();
    setInst(0,  addi(1, 0, 32'h5A));
    setInst(4,  encS(16, 1, 0, 0));
    setInst(8,  addi(2, 0, 32'h11));
    setInst(12, encS(17, 2, 0, 0));
    setInst(16, addi(4, 0, 5));
    setInst(20, encS(17, 1, 0, 0));
    endReset();
    applyStimulus(5);
    checkOutput("pre_reset_pc", dut.pc, 32'd20);
    checkOutput("pre_reset_x4", dut.regs[4], 32'd5);
    beginReset();
    endReset();
    checkOutput("midrun_pc", dut.pc, 32'h0);
    for (int i = 1; i <= 4; i++) checkOutput($sformatf("midrun_x%0d", i), dut.regs[i], 32'h0);
    checkOutput("dmem16_kept", {24'b0, dut.dmem[16]}, 32'h5A);
    checkOutput("dmem17_no_write_in_reset", {24'b0, dut.dmem[17]}, 32'h11);
    checkOutput("dmem3_kept", {24'b0, dut.dmem[3]}, 32'hFF);
    applyStimulus(1);
    checkOutput("restart_x1", dut.regs[1], 32'h5A);
    checkOutput("restart_pc", dut.pc, 32'h4);

    // ECALL handling
    beginReset();
    clearProgram();
    setInst(0,  addi(1, 0, 1));
    setInst(8,  32'h0000_0073);
    setInst(12, addi(2, 0, 2));
    endReset();
`ifdef ECALL_HALT_EN
    applyStimulus(12);
    checkOutput("halt_pc", dut.pc, 32'h08);
    checkOutput("halt_no_write_x2", dut.regs[2], 32'h0);
    beginReset();
    endReset();
    checkOutput("halt_reset_pc", dut.pc, 32'h0);
    applyStimulus(1);
    checkOutput("halt_resume_pc", dut.pc, 32'h4);
`else
    applyStimulus(4);
    checkOutput("ecall_nop_pc", dut.pc, 32'h10);
    checkOutput("ecall_nop_x2", dut.regs[2], 32'h2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
